z1010_ff_slice: RTL

Z1010_FF_SLICE -- requirements
Module: z1010_ff_slice

---
 rtl/z1010_ff_slice.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/z1010_ff_slice.sv
// Configurable fabric flop slice: a serial config chain sets a per-flop mode (plain, async/sync set/clear, enable).
// Optional build macro: Z1010_CFG_PARITY_EN adds a trailing even-parity bit to the chain and an ERROR state.
module z1010_ff_slice #(
    parameter int unsigned NUM_FF = 4,
    parameter int unsigned CFG_W  = 4
) (
    input  logic              clk,
    input  logic              R,
    input  logic              cfg_en,
    input  logic              cfg_din,
    output logic              cfg_dout,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [NUM_FF-1:0] D,
    input  logic [NUM_FF-1:0] E,
    input  logic [NUM_FF-1:0] SR,
    output logic [NUM_FF-1:0] Q
);

    localparam int unsigned MODE_W = NUM_FF * CFG_W;
`ifdef Z1010_CFG_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned CHAIN_W = MODE_W + PAR_W;
    localparam int unsigned CNT_W   = $clog2(CHAIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_W);

    localparam logic [2:0] M_ACLR = 3'd1;
    localparam logic [2:0] M_ASET = 3'd2;
    localparam logic [2:0] M_SSET = 3'd3;
    localparam logic [2:0] M_SCLR = 3'd4;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        SHIFT  = 2'd1,
`ifdef Z1010_CFG_PARITY_EN
        LOCKED = 2'd2,
        ERROR  = 2'd3
`else
        LOCKED = 2'd2
`endif
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           rst_sync;
    logic                 ready;
    logic [CHAIN_W-1:0]   sreg;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 done_r;
    logic [NUM_FF-1:0]    q_reg;
    logic [NUM_FF-1:0]    q_nxt;
    logic [NUM_FF-1:0]    q_out;
    logic [CFG_W-1:0]     mode [NUM_FF];
    logic                 locked;
    logic                 run;

    // Reset release is synchronised; the FSM may not leave UNCFG until it has propagated
    always_ff @(posedge clk or negedge R) begin
        if (!R) rst_sync <= 2'b00;
        else    rst_sync <= {rst_sync[0], 1'b1};
    end
    assign ready = rst_sync[1];

    always_ff @(posedge clk or negedge R) begin
        if (!R) state <= UNCFG;
        else    state <= state_nxt;
    end

    // Next-state: entry edge clears the counter, SHIFT cycles capture bits
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        case (state)
            UNCFG: begin
                if (ready && cfg_en) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (cfg_en) begin
                    shift_en = 1'b1;
                end else if (cnt == CNT_FULL) begin
`ifdef Z1010_CFG_PARITY_EN
                    state_nxt = (^sreg) ? ERROR : LOCKED;
`else
                    state_nxt = LOCKED;
`endif
                end else begin
                    state_nxt = UNCFG;
                    cnt_clr   = 1'b1;
                end
            end
            LOCKED: begin
                if (cfg_en) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
`ifdef Z1010_CFG_PARITY_EN
            ERROR: begin
                if (cfg_en) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
`endif
            default: state_nxt = UNCFG;
        endcase
    end

    // Config chain: shifts right so the first bit in lands at bit 0 of flop 0
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt  <= '0;
            sreg <= '0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (shift_en && (cnt != CNT_FULL))
                cnt <= cnt + CNT_W'(1);
            if (shift_en)
                sreg <= {cfg_din, sreg[CHAIN_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) done_r <= 1'b0;
        else    done_r <= (state_nxt == LOCKED);
    end
    assign cfg_done = done_r;
    assign cfg_dout = sreg[0];

`ifdef Z1010_CFG_PARITY_EN
    logic err_r;
    always_ff @(posedge clk or negedge R) begin
        if (!R) err_r <= 1'b0;
        else    err_r <= (state_nxt == ERROR);
    end
    assign cfg_err = err_r;
`else
    assign cfg_err = 1'b0;
`endif

    assign locked = (state == LOCKED);
    assign run    = locked && (state_nxt == LOCKED);

    // Per-flop capture (enable is a recirculation mux) and async set/clear output override
    always_comb begin
        q_nxt = '0;
        q_out = q_reg;
        for (int unsigned i = 0; i < NUM_FF; i++) begin
            mode[i] = sreg[i*CFG_W +: CFG_W];
            if (run) begin
                if (!SR[i] && (mode[i][3:1] == M_ACLR || mode[i][3:1] == M_SCLR))
                    q_nxt[i] = 1'b0;
                else if (!SR[i] && (mode[i][3:1] == M_ASET || mode[i][3:1] == M_SSET))
                    q_nxt[i] = 1'b1;
                else if (E[i] || !mode[i][0])
                    q_nxt[i] = D[i];
                else
                    q_nxt[i] = q_reg[i];
            end
            if (locked && !SR[i] && mode[i][3:1] == M_ACLR)
                q_out[i] = 1'b0;
            else if (locked && !SR[i] && mode[i][3:1] == M_ASET)
                q_out[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) q_reg <= '0;
        else    q_reg <= q_nxt;
    end
    assign Q = q_out;

endmodule
